ofalu_stall_ctrl: RTL and testbench
===================================

Name: ofalu_stall_ctrl

Overview:
Pipeline interlock controller that drives the hold, bubble and flush controls consumed by the IF/OF and OF/ALU pipeline registers.
- Detects load-use hazards between the OF and ALU stages.
- Freezes the front of the pipe for multi-cycle ALU ops (div/mod).
- Squashes wrong-path instructions on a taken branch resolved in ALU.
- Sits beside the OF/ALU register; its stall_ofalu output is that register's hold input.

Parameters:
MC_LATENCY, 4, number of consecutive stall cycles for a multi-cycle ALU op; legal range 2..15.
CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_of  in  1  OF stage holds a real instruction
rp1_of  in  5  first source register read in OF
uses_rp1_of  in  1  OF instruction actually reads rp1_of
rp2_of  in  5  second source register read in OF
uses_rp2_of  in  1  OF instruction actually reads rp2_of
valid_alu  in  1  ALU stage holds a real instruction
rd_alu  in  5  destination register of the ALU-stage instruction
is_ld_alu  in  1  ALU-stage instruction is a load
is_wb_alu  in  1  ALU-stage instruction writes back
mc_op_alu  in  1  ALU-stage instruction is multi-cycle
branch_taken_alu  in  1  taken branch resolved in ALU this cycle
stall_ifof  out  1  hold the IF/OF register
stall_ofalu  out  1  hold the OF/ALU register
bubble_ofalu  out  1  load a NOP into the OF/ALU register
bubble_alu_ma  out  1  load a NOP into the ALU/MA register
flush_ifof  out  1  squash the IF/OF register contents
flush_ofalu  out  1  squash the OF/ALU register contents
mc_busy  out  1  multi-cycle op in progress
mc_done  out  1  one-cycle pulse: multi-cycle op released
stall_cycles  out  CNT_W  saturating count of cycles with stall_ifof=1

Behaviour:
- States: RUN, MC_WAIT. Registered elements: state, cnt[3:0], mc_done, stall_cycles. All other outputs are combinational from state and inputs.
- Reset (asynchronous, any time, including mid-MC_WAIT):
  - state=RUN, cnt=0, mc_done=0, stall_cycles=0.
  - All combinational outputs evaluate to 0 while rst=1.
- Load-use hazard: luh = valid_alu & is_ld_alu & is_wb_alu & valid_of & ((uses_rp1_of & rp1_of==rd_alu) | (uses_rp2_of & rp2_of==rd_alu)). Register 0 is not special.
- RUN priority, highest first:
  1. branch_taken_alu & valid_alu: flush_ifof=1, flush_ofalu=1; no stall, no bubble.
  2. mc_op_alu & valid_alu & ~mc_done: stall_ifof=1, stall_ofalu=1, bubble_alu_ma=1, mc_busy=1. Load cnt=MC_LATENCY-1 and go to MC_WAIT.
  3. luh: stall_ifof=1, bubble_ofalu=1, stall_ofalu=0. Lasts one cycle; the load then leaves ALU and the hazard clears without further state.
- MC_WAIT:
  - Outputs: stall_ifof=1, stall_ofalu=1, bubble_alu_ma=1, mc_busy=1.
  - Ignored: branch_taken_alu, luh, mc_op_alu.
  - cnt decrements each cycle. When cnt==1: set mc_done<=1 and go to RUN.
  - Total stall is exactly MC_LATENCY cycles.
- mc_done:
  - High for exactly the first RUN cycle after MC_WAIT, then cleared.
  - While high it suppresses mc_op_alu re-triggering, because the same op is still in ALU that cycle and advances at its end.
  - ALU occupancy of a multi-cycle op is MC_LATENCY+1 cycles.
- Output invariants: bubble_ofalu and stall_ofalu are never both 1. Flush outputs are never 1 while any stall output is 1.
- stall_cycles increments on every cycle with stall_ifof=1 and saturates at all-ones, with no wrap.

Decomposition:
- Package simplerisc_pipe_pkg holds:
  - REG_W=5.
  - Enum ctrl_state_t {RUN, MC_WAIT}.
  - Function raw_match(rp, uses, rd) used for hazard compares.
- One sub-module, mc_stall_counter:
  - Inputs: load, load value, enable.
  - Outputs: cnt, last (cnt==1).
  - Instantiated once.

Test Plan:
1. Load hazard: is_ld_alu=1, is_wb_alu=1, rd_alu=5, rp2_of=5, uses_rp2_of=1, both valid -> one cycle of stall_ifof=1, bubble_ofalu=1, stall_ofalu=0; next cycle with a non-load in ALU all 0; stall_cycles=1.
2. MC_LATENCY=4, mc_op_alu held high 6 cycles -> stall_ifof/stall_ofalu/mc_busy=1 for cycles 0-3; mc_done=1 with stalls 0 on cycle 4; no re-trigger; stall_cycles=4.
3. branch_taken_alu=1 with luh=1 in the same cycle -> flush_ifof=flush_ofalu=1, stall_ifof=0, bubble_ofalu=0.
4. branch_taken_alu=1 asserted during MC_WAIT cycle 2 -> no flush; stall sequence unchanged, still 4 cycles.
5. rst pulsed in MC_WAIT with cnt=2 -> all outputs 0 immediately and asynchronously; next mc_op_alu restarts a full 4-cycle stall.
6. Force 65540 stall cycles with CNT_W=16 -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/ofalu_stall_ctrl_pkg.sv
//============================================================================
// Module      : simplerisc_pipe_pkg
// Description : Shared types and helpers for the OF/ALU interlock controller.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

package simplerisc_pipe_pkg;

  // Architectural register index width
  localparam int REG_W    = 5;
  // Width of the multi-cycle stall down-counter (MC_LATENCY up to 15)
  localparam int MC_CNT_W = 4;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } ctrl_state_t;

  // True when a source operand that is actually read matches a destination.
  // Register 0 is treated like any other register.
  function automatic logic raw_match(input logic [REG_W-1:0] rp,
                                     input logic             uses,
                                     input logic [REG_W-1:0] rd);
    return uses & (rp == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ofalu_stall_ctrl_if.sv
//============================================================================
// Module      : ofalu_stall_ctrl_if
// Description : Pipeline-status inputs and interlock controls exchanged
//               between the pipeline datapath and the stall controller.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

interface ofalu_stall_ctrl_if
  import simplerisc_pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  // OF-stage operand usage
  logic             valid_of;
  logic [REG_W-1:0] rp1_of;
  logic             uses_rp1_of;
  logic [REG_W-1:0] rp2_of;
  logic             uses_rp2_of;
  // ALU-stage instruction attributes
  logic             valid_alu;
  logic [REG_W-1:0] rd_alu;
  logic             is_ld_alu;
  logic             is_wb_alu;
  logic             mc_op_alu;
  logic             branch_taken_alu;
  // Interlock controls
  logic             stall_ifof;
  logic             stall_ofalu;
  logic             bubble_ofalu;
  logic             bubble_alu_ma;
  logic             flush_ifof;
  logic             flush_ofalu;
  logic             mc_busy;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: reports stage status, consumes interlock controls
  modport master (
    output valid_of, rp1_of, uses_rp1_of, rp2_of, uses_rp2_of,
    output valid_alu, rd_alu, is_ld_alu, is_wb_alu, mc_op_alu, branch_taken_alu,
    input  stall_ifof, stall_ofalu, bubble_ofalu, bubble_alu_ma,
    input  flush_ifof, flush_ofalu, mc_busy, mc_done, stall_cycles
  );

  // Controller side
  modport slave (
    input  valid_of, rp1_of, uses_rp1_of, rp2_of, uses_rp2_of,
    input  valid_alu, rd_alu, is_ld_alu, is_wb_alu, mc_op_alu, branch_taken_alu,
    output stall_ifof, stall_ofalu, bubble_ofalu, bubble_alu_ma,
    output flush_ifof, flush_ofalu, mc_busy, mc_done, stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/ofalu_stall_ctrl_mc_stall_counter.sv
//============================================================================
// Module      : mc_stall_counter
// Description : Loadable down-counter timing the multi-cycle ALU stall.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module mc_stall_counter
  import simplerisc_pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [MC_CNT_W-1:0] i_load_val,
  input  logic                i_en,
  output logic [MC_CNT_W-1:0] o_cnt,
  output logic                o_last
);

  logic [MC_CNT_W-1:0] r_cnt;

  // Load takes precedence over decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == MC_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/ofalu_stall_ctrl.sv
//============================================================================
// Module      : ofalu_stall_ctrl
// Description : OF/ALU pipeline interlock: load-use bubbles, multi-cycle
//               ALU freeze, taken-branch squash and a stall-cycle counter.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module ofalu_stall_ctrl
  import simplerisc_pipe_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
)(
  input  logic               clk,
  input  logic               rst,
  ofalu_stall_ctrl_if.slave  bus
);

  // Cycles remaining after the trigger cycle itself
  localparam logic [MC_CNT_W-1:0] c_mc_load = MC_CNT_W'(MC_LATENCY - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic                r_mc_done;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic                w_luh;
  logic                w_br;
  logic                w_mc_trig;
  logic                w_cnt_load;
  logic                w_cnt_en;
  logic [MC_CNT_W-1:0] w_cnt;
  logic                w_cnt_last;
  logic                w_mc_release;

  logic                w_stall_ifof;
  logic                w_stall_ofalu;
  logic                w_bubble_ofalu;
  logic                w_bubble_alu_ma;
  logic                w_flush_ifof;
  logic                w_flush_ofalu;
  logic                w_mc_busy;

  // Hazard and trigger qualification from the current stage contents
  always_comb begin
    w_luh = bus.valid_alu & bus.is_ld_alu & bus.is_wb_alu & bus.valid_of &
            (raw_match(bus.rp1_of, bus.uses_rp1_of, bus.rd_alu) |
             raw_match(bus.rp2_of, bus.uses_rp2_of, bus.rd_alu));
    w_br  = bus.branch_taken_alu & bus.valid_alu;
    // mc_done masks the op that just finished, still sitting in ALU
    w_mc_trig = bus.mc_op_alu & bus.valid_alu & ~r_mc_done;
  end

  mc_stall_counter u_mc_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (c_mc_load),
    .i_en       (w_cnt_en),
    .o_cnt      (w_cnt),
    .o_last     (w_cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control; a taken branch outranks a multi-cycle start
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      RUN: begin
        if (!w_br && w_mc_trig) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = MC_WAIT;
        end
      end
      MC_WAIT: begin
        // Never decrement past zero
        w_cnt_en = (w_cnt != '0);
        if (w_cnt_last) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_mc_release = (r_state == MC_WAIT) & w_cnt_last;

  // Interlock outputs; all forced low while reset is asserted
  always_comb begin
    w_stall_ifof    = 1'b0;
    w_stall_ofalu   = 1'b0;
    w_bubble_ofalu  = 1'b0;
    w_bubble_alu_ma = 1'b0;
    w_flush_ifof    = 1'b0;
    w_flush_ofalu   = 1'b0;
    w_mc_busy       = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (w_br) begin
            w_flush_ifof  = 1'b1;
            w_flush_ofalu = 1'b1;
          end else if (w_mc_trig) begin
            w_stall_ifof    = 1'b1;
            w_stall_ofalu   = 1'b1;
            w_bubble_alu_ma = 1'b1;
            w_mc_busy       = 1'b1;
          end else if (w_luh) begin
            w_stall_ifof   = 1'b1;
            w_bubble_ofalu = 1'b1;
          end
        end
        MC_WAIT: begin
          w_stall_ifof    = 1'b1;
          w_stall_ofalu   = 1'b1;
          w_bubble_alu_ma = 1'b1;
          w_mc_busy       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One-cycle release pulse for the first RUN cycle after MC_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mc_done <= 1'b0;
    end else begin
      r_mc_done <= w_mc_release;
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall_ifof && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.stall_ifof    = w_stall_ifof;
  assign bus.stall_ofalu   = w_stall_ofalu;
  assign bus.bubble_ofalu  = w_bubble_ofalu;
  assign bus.bubble_alu_ma = w_bubble_alu_ma;
  assign bus.flush_ifof    = w_flush_ifof;
  assign bus.flush_ofalu   = w_flush_ofalu;
  assign bus.mc_busy       = w_mc_busy;
  assign bus.mc_done       = r_mc_done;
  assign bus.stall_cycles  = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_ofalu_stall_ctrl.sv
//============================================================================
// Module      : tb_ofalu_stall_ctrl
// Description : Self-checking bench for the OF/ALU interlock controller.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ofalu_stall_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 16;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ofalu_stall_ctrl_if #(.CNT_W(CW)) bus ();

  ofalu_stall_ctrl #(.MC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stall cycles still owed, release flag, stall tally
  int m_rem;
  bit m_done;
  int m_cnt;
  bit e_sif, e_sof, e_bof, e_bam, e_fif, e_fof, e_busy, e_trig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.valid_of = 0; bus.rp1_of = 0; bus.uses_rp1_of = 0;
    bus.rp2_of = 0; bus.uses_rp2_of = 0; bus.valid_alu = 0;
    bus.rd_alu = 0; bus.is_ld_alu = 0; bus.is_wb_alu = 0;
    bus.mc_op_alu = 0; bus.branch_taken_alu = 0;
  endtask

  task automatic set_luh();
    idle();
    bus.valid_alu = 1; bus.is_ld_alu = 1; bus.is_wb_alu = 1; bus.rd_alu = 5;
    bus.valid_of = 1; bus.rp1_of = 3; bus.uses_rp1_of = 1;
    bus.rp2_of = 5; bus.uses_rp2_of = 1;
  endtask

  // Evaluate the model at mid-cycle and compare every output
  task automatic settle_check();
    bit luh;
    @(negedge clk);
    luh = bus.valid_alu && bus.is_ld_alu && bus.is_wb_alu && bus.valid_of &&
          ((bus.uses_rp1_of && bus.rp1_of == bus.rd_alu) ||
           (bus.uses_rp2_of && bus.rp2_of == bus.rd_alu));
    {e_sif, e_sof, e_bof, e_bam, e_fif, e_fof, e_busy, e_trig} = '0;
    if (m_rem > 0) begin
      e_sif = 1; e_sof = 1; e_bam = 1; e_busy = 1;
    end else if (bus.branch_taken_alu && bus.valid_alu) begin
      e_fif = 1; e_fof = 1;
    end else if (bus.mc_op_alu && bus.valid_alu && !m_done) begin
      e_sif = 1; e_sof = 1; e_bam = 1; e_busy = 1; e_trig = 1;
    end else if (luh) begin
      e_sif = 1; e_bof = 1;
    end
    chk("stall_ifof",    bus.stall_ifof,    e_sif);
    chk("stall_ofalu",   bus.stall_ofalu,   e_sof);
    chk("bubble_ofalu",  bus.bubble_ofalu,  e_bof);
    chk("bubble_alu_ma", bus.bubble_alu_ma, e_bam);
    chk("flush_ifof",    bus.flush_ifof,    e_fif);
    chk("flush_ofalu",   bus.flush_ofalu,   e_fof);
    chk("mc_busy",       bus.mc_busy,       e_busy);
    chk("mc_done",       bus.mc_done,       m_done);
    chk("stall_cycles",  bus.stall_cycles,  m_cnt);
  endtask

  // Clock edge: advance the model, then move off the edge
  task automatic advance();
    @(posedge clk);
    if (e_sif && m_cnt < MAXC) m_cnt++;
    if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
    end else if (e_trig) begin
      m_rem  = LAT - 1;
      m_done = 0;
    end else begin
      m_done = 0;
    end
    #1;
  endtask

  // Asynchronous reset mid-cycle: everything must drop with no clock edge
  task automatic apply_reset(input string tag);
    rst = 1;
    #1;
    chk({tag, "_rst_sif"},  bus.stall_ifof,    0);
    chk({tag, "_rst_sof"},  bus.stall_ofalu,   0);
    chk({tag, "_rst_bof"},  bus.bubble_ofalu,  0);
    chk({tag, "_rst_bam"},  bus.bubble_alu_ma, 0);
    chk({tag, "_rst_fif"},  bus.flush_ifof,    0);
    chk({tag, "_rst_fof"},  bus.flush_ofalu,   0);
    chk({tag, "_rst_busy"}, bus.mc_busy,       0);
    chk({tag, "_rst_done"}, bus.mc_done,       0);
    chk({tag, "_rst_cnt"},  bus.stall_cycles,  0);
    @(posedge clk);
    #1;
    rst = 0;
    m_rem = 0; m_done = 0; m_cnt = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_rem = 0; m_done = 0; m_cnt = 0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    apply_reset("init");

    // Load-use hazard: one bubble cycle, then clear
    set_luh();
    settle_check();
    chk("t1_sif", bus.stall_ifof, 1);
    chk("t1_bof", bus.bubble_ofalu, 1);
    chk("t1_sof", bus.stall_ofalu, 0);
    advance();
    bus.is_ld_alu = 0;
    settle_check();
    chk("t1_clr_sif", bus.stall_ifof, 0);
    chk("t1_clr_bof", bus.bubble_ofalu, 0);
    chk("t1_cnt", bus.stall_cycles, 1);
    advance();

    // Multi-cycle op: LAT stall cycles, then a release cycle with no re-trigger
    apply_reset("t2");
    idle();
    bus.valid_alu = 1; bus.mc_op_alu = 1;
    for (int i = 0; i <= LAT; i++) begin
      settle_check();
      if (i < LAT) begin
        chk("t2_sif", bus.stall_ifof, 1);
        chk("t2_sof", bus.stall_ofalu, 1);
        chk("t2_busy", bus.mc_busy, 1);
      end else begin
        chk("t2_rel_sif", bus.stall_ifof, 0);
        chk("t2_rel_done", bus.mc_done, 1);
        chk("t2_cnt", bus.stall_cycles, LAT);
      end
      advance();
    end
    idle();
    settle_check();
    chk("t2_done_clr", bus.mc_done, 0);
    advance();

    // Taken branch outranks a simultaneous load-use hazard
    apply_reset("t3");
    set_luh();
    bus.branch_taken_alu = 1;
    settle_check();
    chk("t3_fif", bus.flush_ifof, 1);
    chk("t3_fof", bus.flush_ofalu, 1);
    chk("t3_sif", bus.stall_ifof, 0);
    chk("t3_bof", bus.bubble_ofalu, 0);
    advance();

    // Branch during MC_WAIT is ignored
    apply_reset("t4");
    idle();
    bus.valid_alu = 1; bus.mc_op_alu = 1;
    for (int i = 0; i <= LAT; i++) begin
      bus.branch_taken_alu = (i == 2);
      settle_check();
      if (i < LAT) begin
        chk("t4_sif", bus.stall_ifof, 1);
        chk("t4_fif", bus.flush_ifof, 0);
      end else begin
        chk("t4_done", bus.mc_done, 1);
        chk("t4_cnt", bus.stall_cycles, LAT);
      end
      advance();
    end
    idle();

    // Reset in MC_WAIT (counter at 2), then a fresh full stall
    apply_reset("t5a");
    bus.valid_alu = 1; bus.mc_op_alu = 1;
    settle_check(); advance();
    settle_check(); advance();
    apply_reset("t5");
    for (int i = 0; i <= LAT; i++) begin
      settle_check();
      if (i == LAT - 1) chk("t5_last_sif", bus.stall_ifof, 1);
      if (i == LAT) begin
        chk("t5_done", bus.mc_done, 1);
        chk("t5_cnt", bus.stall_cycles, LAT);
      end
      advance();
    end
    idle();

    // Randomized traffic with a small register space to provoke matches
    apply_reset("rnd");
    for (int n = 0; n < 400; n++) begin
      bus.valid_of         = 1'($urandom_range(0, 3) != 0);
      bus.rp1_of           = 5'($urandom_range(0, 3));
      bus.uses_rp1_of      = 1'($urandom);
      bus.rp2_of           = 5'($urandom_range(0, 3));
      bus.uses_rp2_of      = 1'($urandom);
      bus.valid_alu        = 1'($urandom_range(0, 3) != 0);
      bus.rd_alu           = 5'($urandom_range(0, 3));
      bus.is_ld_alu        = 1'($urandom);
      bus.is_wb_alu        = 1'($urandom_range(0, 3) != 0);
      bus.mc_op_alu        = 1'($urandom_range(0, 7) == 0);
      bus.branch_taken_alu = 1'($urandom_range(0, 5) == 0);
      settle_check();
      advance();
    end
    idle();

    // Saturation of the stall counter
    apply_reset("t6");
    set_luh();
    for (int n = 0; n < 65540; n++) begin
      settle_check();
      advance();
    end
    @(negedge clk);
    chk("t6_sat", bus.stall_cycles, 16'hFFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
